rgbw_pwm_engine: RTL and testbench
==================================

# rgbw_pwm_engine

Four-channel, 8-bit PWM generator driving the red, green, blue and white LED power stages. It sits directly downstream of the colour generator, which presents four duty bytes plus a load strobe, and upstream of the output pins. Duties are double-buffered and take effect only at a PWM period boundary, so colour updates never produce runt or glitched pulses. The counter advances on the shared prescaler tick (`clk_half`).

## Interface
Parameters:
- none; all constants live in `rgbw_pkg`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: already decided as synchronous, active-low, clock `clk`.
- `clk_half` in 1: prescaler clock-enable, one `clk` wide; the counter advances only when it is high.
- `out_en` in 1: output enable; when low, all outputs are forced to 0.
- `load` in 1: one-cycle strobe that captures `duty0..3` into the pending registers.
- `duty0`..`duty3` in 8 each: requested duty for red, green, blue and white.
- `d0`..`d3` out 1 each: PWM outputs for red, green, blue and white.
- `period_start` out 1: one-`clk` pulse at each period wrap.
- `upd_ack` out 1: one-`clk` pulse when pending duties are transferred to active.

## Operation
- Period counter `cnt` runs over 0..254, giving 255 ticks per period. It advances by 1 on each `clk` edge where `clk_half`=1. From 254 it wraps to 0.
- Channel phase:
  - With staggering compiled out, `ph_n = cnt`.
  - With staggering compiled in, `ph_n = cnt + OFS_n`, minus 255 if the sum is ≥ 255.
- Channel output: `d_n` is registered as `out_en & (ph_n < act_n)`.
  - Duty 0 means always low.
  - Duty 255 means always high.
  - Duty k gives exactly k high ticks per period.
- Load: on `load`=1, `pend_n` ← `duty_n` for all four channels and `pend_v` ← 1. Repeated loads within one period overwrite; the last one wins.
- Transfer: on the wrap edge (`clk_half`=1 and `cnt`=254) with `pend_v`=1:
  - `act_n` ← `pend_n`;
  - `pend_v` ← 0;
  - `upd_ack` pulses.
- `load` on the same edge as a wrap: the transfer uses the pre-edge `pend` values. The new values become pending and `pend_v` stays 1 (set wins over clear). They apply at the following wrap.
- Wrap with `pend_v`=0: `act` is unchanged and there is no `upd_ack`.
- `out_en` low: the counter, load and transfer logic keep running; only the outputs are gated.

## Timing
- Reset values: `cnt`=0, `act`=0, `pend`=0, `pend_v`=0, `d0..d3`=0, `period_start`=0, `upd_ack`=0.
- Reset during a period: takes effect at the next edge and overrides `load` and `clk_half` on that same edge.
- `d_n` lags the counter by 1 `clk`: an output reflects the `cnt`/`act` values held before the edge.
- `period_start` and `upd_ack` are registered. They are high for exactly the one `clk` following the wrap edge.
- Load-to-output latency: at most one full period, 255 `clk_half` ticks, plus 1 `clk`.
- `out_en` gating latency: 1 `clk`.
- `clk_half` tied to 1 gives a period of 255 `clk` cycles.

## Configuration
- Macro `RGBW_PWM_PHASE_STAGGER_EN`.
- Defined: channel offsets `OFS` = 0, 64, 128, 192. Rising edges are spread across the period to reduce simultaneous switching current. Duty ratios are unchanged.
- Undefined: all offsets are 0. All non-zero channels rise together one `clk` after `cnt` wraps to 0.

## Structure
- Package `rgbw_pkg`, shared with the colour generator:
  - `PWM_PERIOD`=255;
  - `NUM_CH`=4;
  - `PWM_W`=8;
  - `PHASE_OFS[NUM_CH]`;
  - `duty_t` typedef.
- Sub-module `rgbw_pwm_channel`, instantiated 4×: pending/active registers, phase add-and-wrap, comparator and output register. The top holds the counter, wrap detection, `pend_v` and the pulses.

## Test plan
- Reset release with `clk_half`=1, no load → `d0..d3` stay 0, `period_start` every 255 clocks, no `upd_ack`.
- Load duties 0, 1, 128, 255 mid-period → no output change until wrap; `upd_ack` once; then per period `d0`=0 high, `d1`=1 high, `d2`=128 high, `d3`=255 high clocks.
- Load 50 then 200 within one period → only 200 is applied; a single `upd_ack`.
- `load` with `duty0`=10 on the `cnt`=254 edge while pending holds 100 → next period uses 100; the period after uses 10.
- `clk_half` every 4th clock, duty 64 → period of 1020 clocks with 256 clocks high; drop `out_en` → outputs 0 after 1 clock, counter phase preserved.
- With `RGBW_PWM_PHASE_STAGGER_EN`, all duties 32 → rising edges of `d1`, `d2`, `d3` occur at `cnt`=191, 127, 63 (+1 `clk`); assert reset mid-period → all outputs 0 on the next clock.

Source files
------------

// File: rtl/rgbw_pkg.sv
// Constants and types shared by the RGBW colour generator and PWM engine.
// RGBW_PWM_PHASE_STAGGER_EN selects per-channel phase offsets 0/64/128/192 instead of all-zero.
package rgbw_pkg;

  localparam int unsigned PWM_PERIOD = 255;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned PWM_W      = 8;
  localparam int unsigned SUM_W      = PWM_W + 1;

  typedef logic [PWM_W-1:0] duty_t;
  typedef logic [SUM_W-1:0] sum_t;

`ifdef RGBW_PWM_PHASE_STAGGER_EN
  localparam duty_t PHASE_OFS [NUM_CH] = '{8'd0, 8'd64, 8'd128, 8'd192};
`else
  localparam duty_t PHASE_OFS [NUM_CH] = '{default: '0};
`endif

  localparam duty_t CNT_LAST = duty_t'(PWM_PERIOD - 1);

  // Counter plus offset, folded back into 0..PWM_PERIOD-1.
  function automatic duty_t phase_wrap(input duty_t cnt, input duty_t ofs);
    sum_t sum;
    sum = sum_t'(cnt) + sum_t'(ofs);
    if (sum >= sum_t'(PWM_PERIOD)) begin
      sum = sum - sum_t'(PWM_PERIOD);
    end
    return sum[PWM_W-1:0];
  endfunction

endpackage

// File: rtl/rgbw_pwm_channel.sv
// One PWM channel: double-buffered duty, phase offset, comparator and output register.
module rgbw_pwm_channel
  import rgbw_pkg::*;
#(
  parameter duty_t OFS = '0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_load,
  input  duty_t i_duty,
  input  logic  i_xfer,
  input  duty_t i_cnt,
  input  logic  i_out_en,
  output logic  o_d
);

  duty_t r_pend;
  duty_t r_act;
  logic  r_d;
  duty_t w_ph;

  assign w_ph = phase_wrap(i_cnt, OFS);

  // Transfer reads the pre-edge pending value, so a same-edge load lands for the next wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend <= '0;
      r_act  <= '0;
      r_d    <= 1'b0;
    end else begin
      if (i_load) begin
        r_pend <= i_duty;
      end
      if (i_xfer) begin
        r_act <= r_pend;
      end
      r_d <= i_out_en & (w_ph < r_act);
    end
  end

  assign o_d = r_d;

endmodule

// File: rtl/rgbw_pwm_engine.sv
// Four-channel 8-bit RGBW PWM engine with period-aligned duty updates.
// Build with RGBW_PWM_PHASE_STAGGER_EN to stagger channel phases (see rgbw_pkg).
module rgbw_pwm_engine
  import rgbw_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_half,
  input  logic             out_en,
  input  logic             load,
  input  logic [PWM_W-1:0] duty0,
  input  logic [PWM_W-1:0] duty1,
  input  logic [PWM_W-1:0] duty2,
  input  logic [PWM_W-1:0] duty3,
  output logic             d0,
  output logic             d1,
  output logic             d2,
  output logic             d3,
  output logic             period_start,
  output logic             upd_ack
);

  duty_t             r_cnt;
  logic              r_pend_v;
  logic              r_period_start;
  logic              r_upd_ack;
  logic              w_wrap;
  logic              w_xfer;
  duty_t             w_duty [NUM_CH];
  logic [NUM_CH-1:0] w_d;

  assign w_wrap = clk_half & (r_cnt == CNT_LAST);
  assign w_xfer = w_wrap & r_pend_v;

  // Period counter, pending flag (load wins over transfer clear) and status pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt          <= '0;
      r_pend_v       <= 1'b0;
      r_period_start <= 1'b0;
      r_upd_ack      <= 1'b0;
    end else begin
      if (clk_half) begin
        r_cnt <= w_wrap ? '0 : r_cnt + duty_t'(1);
      end
      if (load) begin
        r_pend_v <= 1'b1;
      end else if (w_xfer) begin
        r_pend_v <= 1'b0;
      end
      r_period_start <= w_wrap;
      r_upd_ack      <= w_xfer;
    end
  end

  assign w_duty[0] = duty0;
  assign w_duty[1] = duty1;
  assign w_duty[2] = duty2;
  assign w_duty[3] = duty3;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rgbw_pwm_channel #(
      .OFS (PHASE_OFS[g])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_load   (load),
      .i_duty   (w_duty[g]),
      .i_xfer   (w_xfer),
      .i_cnt    (r_cnt),
      .i_out_en (out_en),
      .o_d      (w_d[g])
    );
  end

  assign d0           = w_d[0];
  assign d1           = w_d[1];
  assign d2           = w_d[2];
  assign d3           = w_d[3];
  assign period_start = r_period_start;
  assign upd_ack      = r_upd_ack;

endmodule

// File: tb/tb_rgbw_pwm_engine.sv
// Scoreboard bench for rgbw_pwm_engine: per-period high counts, lengths, upd_ack and rise positions.
module tb_rgbw_pwm_engine;
  import rgbw_pkg::*;

  typedef struct packed {
    logic [3:0][15:0] hi;
    logic [15:0]      len;
    logic             ack;
    logic             chk_rise;
    logic [3:0][15:0] rise;
  } exp_t;

  localparam logic [15:0] NO_RISE = 16'hFFFF;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  logic  clk_half = 1'b0;
  logic  out_en = 1'b1;
  logic  load = 1'b0;
  duty_t duty0 = '0;
  duty_t duty1 = '0;
  duty_t duty2 = '0;
  duty_t duty3 = '0;
  logic  d0, d1, d2, d3, period_start, upd_ack;

  rgbw_pwm_engine dut (
    .clk          (clk),
    .reset        (reset),
    .clk_half     (clk_half),
    .out_en       (out_en),
    .load         (load),
    .duty0        (duty0),
    .duty1        (duty1),
    .duty2        (duty2),
    .duty3        (duty3),
    .d0           (d0),
    .d1           (d1),
    .d2           (d2),
    .d3           (d3),
    .period_start (period_start),
    .upd_ack      (upd_ack)
  );

  always #5 clk = ~clk;

  exp_t       sb [$];
  logic [3:0] probe_q [$];
  int         checks = 0;
  int         errors = 0;
  int         edge_n = 0;
  bit         div4 = 1'b0;
  int         to_req = 0;
  int         to_seen = 0;
  logic       rst_q = 1'b0;

  logic [3:0][15:0] hi_a;
  logic [3:0][15:0] rise_a;
  int               len_a;
  logic [3:0]       prev_d;

  always @(posedge clk) rst_q <= reset;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic clear_acc();
    hi_a   = '0;
    rise_a = {4{NO_RISE}};
    len_a  = 0;
  endtask

  // Monitor: accumulates each period and checks it against the scoreboard on period_start.
  always @(negedge clk) begin
    logic [3:0] dv;
    logic [3:0] pe;
    exp_t       e;
    dv = {d3, d2, d1, d0};
    if (to_req != to_seen) begin
      to_seen = to_req;
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d periods outstanding, required 0", sb.size());
      sb.delete();
    end
    if (probe_q.size() > 0) begin
      pe = probe_q.pop_front();
      checks++;
      if (dv !== pe) begin
        errors++;
        $display("FAIL probe_d3..d0: got %b required %b", dv, pe);
      end
    end
    if (!rst_q) begin
      clear_acc();
      prev_d = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (dv[c]) hi_a[c] = hi_a[c] + 16'd1;
        if (dv[c] && !prev_d[c] && rise_a[c] == NO_RISE) rise_a[c] = 16'(len_a);
      end
      len_a++;
      prev_d = dv;
      if (upd_ack && !period_start) begin
        checks++;
        errors++;
        $display("FAIL stray_upd_ack: got 1 required 0 outside period_start");
      end
      if (period_start) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_period: got period of %0d clocks required none", len_a);
        end else begin
          e = sb.pop_front();
          cmp("period_len", len_a, int'(e.len));
          cmp("upd_ack", int'(upd_ack), int'(e.ack));
          for (int c = 0; c < 4; c++) begin
            cmp($sformatf("hi_ch%0d", c), int'(hi_a[c]), int'(e.hi[c]));
            if (e.chk_rise) cmp($sformatf("rise_ch%0d", c), int'(rise_a[c]), int'(e.rise[c]));
          end
        end
        clear_acc();
      end
    end
  end

  function automatic exp_t mk(input int h0, input int h1, input int h2, input int h3,
                              input int len, input bit ack);
    exp_t e;
    e.hi[0]    = 16'(h0);
    e.hi[1]    = 16'(h1);
    e.hi[2]    = 16'(h2);
    e.hi[3]    = 16'(h3);
    e.len      = 16'(len);
    e.ack      = ack;
    e.chk_rise = 1'b0;
    e.rise     = {4{NO_RISE}};
    return e;
  endfunction

  task automatic step();
    clk_half = div4 ? (edge_n % 4 == 3) : 1'b1;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int k);
    while (edge_n < k) step();
  endtask

  task automatic set_duty(input duty_t a, input duty_t b, input duty_t c, input duty_t d);
    duty0 = a; duty1 = b; duty2 = c; duty3 = d;
  endtask

  // Reset held with load asserted: reset must win, leaving nothing pending.
  task automatic do_reset();
    reset  = 1'b0;
    div4   = 1'b0;
    out_en = 1'b1;
    load   = 1'b1;
    set_duty(8'hA5, 8'h5A, 8'hC3, 8'h3C);
    step();
    step();
    load   = 1'b0;
    reset  = 1'b1;
    edge_n = 0;
  endtask

  task automatic load_at(input int k, input duty_t a, input duty_t b, input duty_t c, input duty_t d);
    run_to(k);
    set_duty(a, b, c, d);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      to_req++;
      step();
    end
  endtask

  initial begin
    exp_t e;
    int   r_rst;
    logic [3:0] pre_rst;

    // Idle after reset: outputs low, 255-clock periods, no ack.
    do_reset();
    repeat (3) sb.push_back(mk(0, 0, 0, 0, 255, 1'b0));
    wait_drain(1000);

    // Boundary duties 0/1/128/255 loaded mid-period.
    do_reset();
    sb.push_back(mk(0, 0, 0, 0, 255, 1'b1));
    repeat (2) sb.push_back(mk(0, 1, 128, 255, 255, 1'b0));
    load_at(100, 8'd0, 8'd1, 8'd128, 8'd255);
    wait_drain(1000);

    // Two loads in one period: last wins, single ack.
    do_reset();
    sb.push_back(mk(0, 0, 0, 0, 255, 1'b1));
    sb.push_back(mk(200, 10, 0, 255, 255, 1'b0));
    load_at(30, 8'd50, 8'd50, 8'd50, 8'd50);
    load_at(100, 8'd200, 8'd10, 8'd0, 8'd255);
    wait_drain(1000);

    // Load on the wrap edge: pending 100 applies first, 10 the period after.
    do_reset();
    sb.push_back(mk(0, 0, 0, 0, 255, 1'b1));
    sb.push_back(mk(100, 0, 0, 0, 255, 1'b1));
    sb.push_back(mk(10, 0, 0, 0, 255, 1'b0));
    load_at(50, 8'd100, 8'd0, 8'd0, 8'd0);
    load_at(254, 8'd10, 8'd0, 8'd0, 8'd0);
    wait_drain(1000);

    // clk_half every 4th clock, then out_en dropped for 100 clocks in period three.
    do_reset();
    div4 = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 1020, 1'b1));
    sb.push_back(mk(256, 0, 1020, 512, 1020, 1'b0));
    sb.push_back(mk(256, 0, 920, 512, 1020, 1'b0));
    load_at(100, 8'd64, 8'd0, 8'd255, 8'd128);
    run_to(2640);
    probe_q.push_back(4'b0100);
    out_en = 1'b0;
    step();
    probe_q.push_back(4'b0000);
    run_to(2740);
    out_en = 1'b1;
    probe_q.push_back(4'b0000);
    step();
    probe_q.push_back(4'b0100);
    wait_drain(5000);

    // Duty 32 on all channels: rise positions, then reset mid-period.
    do_reset();
    sb.push_back(mk(0, 0, 0, 0, 255, 1'b1));
    e = mk(32, 32, 32, 32, 255, 1'b0);
    e.chk_rise = 1'b1;
`ifdef RGBW_PWM_PHASE_STAGGER_EN
    e.rise[0] = 16'd0;
    e.rise[1] = 16'd191;
    e.rise[2] = 16'd127;
    e.rise[3] = 16'd63;
    r_rst   = 140;
    pre_rst = 4'b0100;
`else
    e.rise  = '0;
    r_rst   = 20;
    pre_rst = 4'b1111;
`endif
    sb.push_back(e);
    load_at(10, 8'd32, 8'd32, 8'd32, 8'd32);
    run_to(510 + r_rst + 1);
    probe_q.push_back(pre_rst);
    reset = 1'b0;
    step();
    probe_q.push_back(4'b0000);
    step();
    reset  = 1'b1;
    edge_n = 0;
    sb.push_back(mk(0, 0, 0, 0, 255, 1'b0));
    wait_drain(1000);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
